stream_upsizer: RTL

STREAM_UPSIZER -- requirements
Module: stream_upsizer

---
 rtl/stream_upsizer_if.sv | 28 ++
 rtl/stream_upsizer.sv | 104 ++++++++++
 2 files changed

// File: rtl/stream_upsizer_if.sv
// Handshake bundle for stream_upsizer: narrow input stream (s_*) and wide packed output stream (m_*).
// The slave modport is the upsizer's view; the master modport is the environment driving it.
interface stream_upsizer_if #(
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned RATIO        = 4
);
  localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;

  logic                    s_val;
  logic [S_DATA_WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    s_rdy;
  logic                    m_val;
  logic [M_DATA_WIDTH-1:0] m_data;
  logic [RATIO-1:0]        m_keep;
  logic                    m_last;
  logic                    m_rdy;

  modport master (
    output s_val, s_data, s_last, m_rdy,
    input  s_rdy, m_val, m_data, m_keep, m_last
  );

  modport slave (
    input  s_val, s_data, s_last, m_rdy,
    output s_rdy, m_val, m_data, m_keep, m_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word; s_last flushes a partial word with zeroed, unkept lanes.
// The completing beat bypasses the accumulator straight into the output register (1-cycle latency).
module stream_upsizer #(
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned RATIO        = 4,
  parameter bit          LSB_FIRST    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  stream_upsizer_if.slave  bus
);
  localparam int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
  localparam int unsigned CW           = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_COUNT = CW'(RATIO - 1);

  logic [CW-1:0]           count;
  logic                    accept;
  logic                    complete;
  logic [S_DATA_WIDTH-1:0] lane_data [RATIO];
  logic                    lane_keep [RATIO];
  logic [M_DATA_WIDTH-1:0] word_c;
  logic [RATIO-1:0]        keep_c;

  logic                    out_val;
  logic [M_DATA_WIDTH-1:0] out_data;
  logic [RATIO-1:0]        out_keep;
  logic                    out_last;

  assign bus.s_rdy = !out_val || bus.m_rdy;
  assign accept    = bus.s_val && bus.s_rdy;
  assign complete  = accept && ((count == LAST_COUNT) || bus.s_last);

  // One slot per beat position; the final position never needs storage since it always completes.
  for (genvar k = 0; k < RATIO; k++) begin : g_beat
    localparam int unsigned LANE = LSB_FIRST ? k : (RATIO - 1 - k);

    if (k < RATIO - 1) begin : g_stored
      logic [S_DATA_WIDTH-1:0] held;
      logic                    valid;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          held  <= '0;
          valid <= 1'b0;
        end else if (complete) begin
          valid <= 1'b0;
        end else if (accept && (count == CW'(k))) begin
          held  <= bus.s_data;
          valid <= 1'b1;
        end
      end

      // Invalid positions read as zero so stale slot contents never reach the output.
      assign lane_data[LANE] = valid ? held :
                               (count == CW'(k)) ? bus.s_data : '0;
      assign lane_keep[LANE] = valid || (count == CW'(k));
    end else begin : g_final
      assign lane_data[LANE] = (count == CW'(k)) ? bus.s_data : '0;
      assign lane_keep[LANE] = (count == CW'(k));
    end
  end

  // Flatten lanes into the output word and keep mask.
  always_comb begin
    word_c = '0;
    keep_c = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      word_c[i*S_DATA_WIDTH +: S_DATA_WIDTH] = lane_data[i];
      keep_c[i]                              = lane_keep[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (complete) begin
      count <= '0;
    end else if (accept) begin
      count <= count + 1'b1;
    end
  end

  // A completing beat may replace a word that is leaving on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else if (complete) begin
      out_val  <= 1'b1;
      out_data <= word_c;
      out_keep <= keep_c;
      out_last <= bus.s_last;
    end else if (bus.m_rdy) begin
      out_val  <= 1'b0;
    end
  end

  assign bus.m_val  = out_val;
  assign bus.m_data = out_data;
  assign bus.m_keep = out_keep;
  assign bus.m_last = out_last;
endmodule
